uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2; legal 2..8).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port fifo_write_tx  input  1  active-low write strobe, one byte per low cycle.
REQ-005 SHALL have port tx_din  input  8  byte to write.
REQ-006 SHALL have port fifo_read_tx  input  1  active-low read strobe from the transmitter.
REQ-007 SHALL have port tx_dout_reg  output  8  registered read data.
REQ-008 SHALL have port fifo_empty  output  1  registered, high when count = 0.
REQ-009 SHALL have port fifo_full  output  1  registered, high when count = depth.
REQ-010 SHALL have port fifo_count  output  DEPTH_LOG2+1  registered occupancy.
REQ-011 SHALL have port clr_overflow  input  1  active-high clear for overflow.
REQ-012 SHALL have port overflow  output  1  sticky overflow flag.

Function
REQ-013 Write accepted when fifo_write_tx=0 and fifo_full=0 (flag value at the sampling edge): mem[wr_ptr] <= tx_din, wr_ptr increments modulo depth.
REQ-014 Read accepted when fifo_read_tx=0 and fifo_empty=0: tx_dout_reg <= mem[rd_ptr] on that edge (1-cycle latency), rd_ptr increments modulo depth.
REQ-015 tx_dout_reg SHALL hold its value on all cycles without an accepted read.
REQ-016 Write with fifo_full=1 SHALL be dropped; pointers, count and memory unchanged, even when a read is accepted the same cycle.
REQ-017 Read with fifo_empty=1 SHALL be ignored; tx_dout_reg, rd_ptr, count unchanged; no write-to-read bypass.
REQ-018 Accepted read and write in the same cycle SHALL leave count unchanged; both pointers advance.
REQ-019 count SHALL update +1 on write only, -1 on read only; never exceeds depth or drops below 0.
REQ-020 fifo_empty/fifo_full SHALL be registered from next-state count, valid the cycle after the causing edge.
REQ-021 Pointers SHALL be DEPTH_LOG2 bits and wrap depth-1 -> 0 with no flag glitch.
REQ-022 Data SHALL exit in write order; a byte read in cycle N is on tx_dout_reg from N+1 until the next accepted read.

Reset
REQ-023 On reset_n=0 at a clk edge: wr_ptr=0, rd_ptr=0, fifo_count=0, fifo_empty=1, fifo_full=0, tx_dout_reg=8'h00, overflow=0.
REQ-024 Reset SHALL take priority over simultaneous read/write; memory contents are not cleared but are unreachable.
REQ-025 Reset mid-operation SHALL discard all stored bytes; first post-reset write is the first byte read.

Configuration
REQ-026 Macro UART_TX_FIFO_OVERFLOW_FLAG_EN SHALL gate the overflow logic.
REQ-027 With macro defined: overflow set the cycle after a dropped write (REQ-016); cleared by clr_overflow=1; set takes priority over clear in the same cycle.
REQ-028 Without macro: overflow tied 0, clr_overflow ignored; all other behaviour identical.

Verification
REQ-029 Reset, then write 8'hA5, 8'h3C, then read twice -> tx_dout_reg = 8'hA5 then 8'h3C, each one cycle after its read; fifo_empty=1 after second read.
REQ-030 DEPTH_LOG2=4: write 16 bytes 8'h00..8'h0F, then a 17th 8'h FF -> fifo_full=1, fifo_count=16, 8'hFF dropped; 16 reads return 00..0F; with macro overflow=1 until clr_overflow pulse.
REQ-031 Read on empty FIFO -> tx_dout_reg holds prior value, fifo_count stays 0, no pointer change.
REQ-032 Count=5, simultaneous read and write for 40 cycles -> fifo_count stays 5, pointers wrap twice, data order preserved.
REQ-033 Count=16 full, simultaneous read and write -> read accepted, write dropped, fifo_count=15.
REQ-034 Count=7, assert reset_n=0 for one cycle with a write pending -> fifo_count=0, fifo_empty=1, tx_dout_reg=8'h00, pending write lost.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO sitting between a host write port and a UART
// transmitter. Occupancy, empty/full flags and read data are all registered.
// The sticky overflow flag is present only when UART_TX_FIFO_OVERFLOW_FLAG_EN
// is defined; otherwise overflow is tied low and clr_overflow is ignored.
//
// Strobe semantics: fifo_write_tx and fifo_read_tx are active-low, one byte
// per low cycle. A write is accepted only when the registered fifo_full is low
// at that edge and a read only when the registered fifo_empty is low; a
// refused strobe has no effect on pointers, count, memory or read data.
// There is no write-to-read bypass: a byte written into an empty FIFO becomes
// readable on the following cycle.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_write_tx,
  input  logic [7:0]            tx_din,
  input  logic                  fifo_read_tx,
  output logic [7:0]            tx_dout_reg,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  input  logic                  clr_overflow,
  output logic                  overflow
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [7:0]            dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_en, rd_en, wr_drop;

  // Accept/drop decisions and next-state pointers, count, flags and read data.
  always_comb begin
    wr_en    = !fifo_write_tx && !full_q;
    rd_en    = !fifo_read_tx && !empty_q;
    wr_drop  = !fifo_write_tx && full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they are valid the cycle after the edge.
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  // Sticky overflow: a dropped write sets it and wins over a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_drop)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end
`else
  logic unused_overflow_inputs;
  assign unused_overflow_inputs = clr_overflow ^ wr_drop;

  // Overflow feature absent: the flag stays low.
  always_comb begin
    overflow_d = 1'b0;
  end
`endif

  // Storage array; not reset, stale bytes are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) mem_q[wr_ptr_q] <= tx_din;
  end

  // Control registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      dout_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_dout_reg = dout_q;
  assign fifo_empty  = empty_q;
  assign fifo_full   = full_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // Clock / reset / DUT signals
  logic                clk = 1'b0;
  logic                reset_n;
  logic                fifo_write_tx;
  logic [7:0]          tx_din;
  logic                fifo_read_tx;
  logic [7:0]          tx_dout_reg;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                clr_overflow;
  logic                overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_write_tx(fifo_write_tx),
    .tx_din       (tx_din),
    .fifo_read_tx (fifo_read_tx),
    .tx_dout_reg  (tx_dout_reg),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .clr_overflow (clr_overflow),
    .overflow     (overflow)
  );

  // Reference model state: expected queue of stored bytes, last read byte, flag.
  logic [7:0] exp_q[$];
  logic [7:0] exp_dout;
  logic       exp_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one clock edge with the given strobes, flags from pre-edge occupancy.
  task automatic model_step(input logic wr_n, input logic [7:0] din, input logic rd_n,
                            input logic clr, input logic rst_n);
    int  n;
    logic was_full;
    n = exp_q.size();
    was_full = (n == DEPTH);
    if (!rst_n) begin
      exp_q.delete();
      exp_dout = 8'h00;
      exp_ovf  = 1'b0;
    end else begin
      if (!rd_n && n != 0) exp_dout = exp_q.pop_front();
      if (!wr_n && !was_full) exp_q.push_back(din);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
      if (!wr_n && was_full) exp_ovf = 1'b1;
      else if (clr)          exp_ovf = 1'b0;
`else
      exp_ovf = 1'b0;
`endif
    end
  endtask

  task automatic compare_all();
    check_eq("dout",     32'(tx_dout_reg), 32'(exp_dout));
    check_eq("count",    32'(fifo_count),  32'(exp_q.size()));
    check_eq("empty",    32'(fifo_empty),  32'(exp_q.size() == 0));
    check_eq("full",     32'(fifo_full),   32'(exp_q.size() == DEPTH));
    check_eq("overflow", 32'(overflow),    32'(exp_ovf));
  endtask

  // Driver: apply inputs, clock once, advance model, sample on the falling edge.
  task automatic drive_cycle(input logic wr_n, input logic [7:0] din, input logic rd_n,
                             input logic clr, input logic rst_n);
    fifo_write_tx = wr_n;
    tx_din        = din;
    fifo_read_tx  = rd_n;
    clr_overflow  = clr;
    reset_n       = rst_n;
    @(posedge clk);
    model_step(wr_n, din, rd_n, clr, rst_n);
    @(negedge clk);
    compare_all();
  endtask

  task automatic write_byte(input logic [7:0] b);
    drive_cycle(1'b0, b, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic read_byte();
    drive_cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    drive_cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;

    // Reset state
    do_reset();
    do_reset();
    check_eq("rst_empty", 32'(fifo_empty), 32'd1);
    check_eq("rst_dout",  32'(tx_dout_reg), 32'h00);

    // Two writes, two reads, data in order with one-cycle latency
    write_byte(8'hA5);
    write_byte(8'h3C);
    read_byte();
    check_eq("first_read", 32'(tx_dout_reg), 32'hA5);
    read_byte();
    check_eq("second_read", 32'(tx_dout_reg), 32'h3C);
    check_eq("empty_after_reads", 32'(fifo_empty), 32'd1);

    // Read on empty holds data and count
    read_byte();
    check_eq("empty_read_hold", 32'(tx_dout_reg), 32'h3C);
    check_eq("empty_read_count", 32'(fifo_count), 32'd0);

    // Fill to depth, then a dropped 17th write
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
    write_byte(8'hFF);
    check_eq("fill_full",  32'(fifo_full),  32'd1);
    check_eq("fill_count", 32'(fifo_count), 32'(DEPTH));
    idle();
    drive_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      read_byte();
      check_eq("drain_order", 32'(tx_dout_reg), 32'(i));
    end

    // Count 5, simultaneous read+write for 40 cycles
    for (int i = 0; i < 5; i++) write_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++)
      drive_cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
    check_eq("steady_count", 32'(fifo_count), 32'd5);

    // Full, simultaneous read+write: read taken, write dropped
    while (exp_q.size() < DEPTH) write_byte(8'($urandom_range(0, 255)));
    drive_cycle(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
    check_eq("full_rw_count", 32'(fifo_count), 32'(DEPTH - 1));
    drive_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);

    // Reset mid-operation with a pending write
    do_reset();
    for (int i = 0; i < 7; i++) write_byte(8'h10 + 8'(i));
    drive_cycle(1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    check_eq("midrst_count", 32'(fifo_count), 32'd0);
    check_eq("midrst_dout",  32'(tx_dout_reg), 32'h00);
    write_byte(8'h5A);
    read_byte();
    check_eq("post_rst_first", 32'(tx_dout_reg), 32'h5A);

    // Randomized traffic with varying write/read pressure and rare resets
    for (int blk = 0; blk < 15; blk++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = $urandom_range(10, 95);
      rd_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        drive_cycle(($urandom_range(0, 99) < wr_pct) ? 1'b0 : 1'b1,
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < rd_pct) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
